// File: rtl/addr_range_pkg.sv
// rtl/addr_range_pkg.sv - shared range and entry types for the address range table
package addr_range_pkg;

  localparam int AW = 32;

  typedef struct packed {
    logic [AW-1:0] first;
    logic [AW-1:0] last;
  } range_t;

  typedef struct packed {
    logic   valid;
    range_t rng;
  } entry_t;

endpackage

// File: rtl/addr_range_match.sv
// rtl/addr_range_match.sv - combinational inclusive range compare with lowest-index priority
module addr_range_match
  import addr_range_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  entry_t [DEPTH-1:0] entries,
  input  logic   [AW-1:0]    addr,
  output logic   [DEPTH-1:0] hit_vec,
  output logic               hit,
  output logic   [IDXW-1:0]  idx
);

  // Scanning downward lets the lowest hitting index win the last assignment.
  always_comb begin
    hit_vec = '0;
    idx     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hit_vec[i] = entries[i].valid &&
                   (entries[i].rng.first <= addr) &&
                   (addr <= entries[i].rng.last);
      if (hit_vec[i]) idx = IDXW'(i);
    end
  end

  assign hit = |hit_vec;

endmodule

// File: rtl/addr_range_table.sv
// rtl/addr_range_table.sv - live object bounds table with alloc/free, registered lookup and occupancy
module addr_range_table #(
  parameter int DEPTH = 8,
  parameter int AW    = addr_range_pkg::AW,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            alloc_i,
  input  logic [AW-1:0]   alloc_first_i,
  input  logic [AW-1:0]   alloc_last_i,
  input  logic            free_i,
  input  logic [AW-1:0]   free_first_i,
  input  logic            lookup_i,
  input  logic [AW-1:0]   lookup_addr_i,
  output logic            lookup_valid_o,
  output logic            lookup_hit_o,
  output logic [IDXW-1:0] lookup_idx_o,
  output logic [AW-1:0]   lookup_first_o,
  output logic [AW-1:0]   lookup_last_o,
  output logic [AW-1:0]   last_first_o,
  output logic [AW-1:0]   last_last_o,
  output logic [IDXW:0]   count_o,
  output logic            full_o,
  output logic            overflow_o,
  output logic            alloc_err_o,
  output logic            free_miss_o
);

  import addr_range_pkg::*;

  entry_t [DEPTH-1:0] ents, ents_d;
  logic   [IDXW-1:0]  wr_ptr, wr_ptr_d, last_ptr;
  logic   [IDXW:0]    count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               alloc_err_q, free_miss_q;
  logic   [DEPTH-1:0] free_hit;
  logic               alloc_ok;

  logic               lk_valid_q, lk_hit_q;
  logic   [IDXW-1:0]  lk_idx_q;
  logic   [AW-1:0]    lk_first_q, lk_last_q;

  logic   [DEPTH-1:0] m_hit_vec;
  logic               m_hit;
  logic   [IDXW-1:0]  m_idx;

  addr_range_match #(
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) u_match (
    .entries (ents),
    .addr    (lookup_addr_i),
    .hit_vec (m_hit_vec),
    .hit     (m_hit),
    .idx     (m_idx)
  );

  assign alloc_ok = alloc_i && (alloc_first_i <= alloc_last_i);

  always_comb begin
    free_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_hit[i] = ents[i].valid && (ents[i].rng.first == free_first_i);
    end
  end

  // Free is applied before alloc so an alloc into a just-freed wr_ptr slot wins.
  always_comb begin
    ents_d     = ents;
    wr_ptr_d   = wr_ptr;
    overflow_d = overflow_q;
    if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) ents_d[i].valid = 1'b0;
      wr_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (free_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (free_hit[i]) ents_d[i].valid = 1'b0;
        end
      end
      if (alloc_ok) begin
        ents_d[wr_ptr].valid     = 1'b1;
        ents_d[wr_ptr].rng.first = alloc_first_i;
        ents_d[wr_ptr].rng.last  = alloc_last_i;
        wr_ptr_d                 = wr_ptr + 1'b1;
        if (ents[wr_ptr].valid) overflow_d = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + {{IDXW{1'b0}}, ents_d[i].valid};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ents        <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      alloc_err_q <= 1'b0;
      free_miss_q <= 1'b0;
      lk_valid_q  <= 1'b0;
      lk_hit_q    <= 1'b0;
      lk_idx_q    <= '0;
      lk_first_q  <= '0;
      lk_last_q   <= '0;
    end else begin
      ents        <= ents_d;
      wr_ptr      <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      alloc_err_q <= !clear_i && alloc_i && (alloc_first_i > alloc_last_i);
      free_miss_q <= !clear_i && free_i && !(|free_hit);
      lk_valid_q  <= lookup_i;
      if (lookup_i) begin
        lk_hit_q   <= m_hit;
        lk_idx_q   <= m_idx;
        lk_first_q <= m_hit_vec[m_idx] ? ents[m_idx].rng.first : '0;
        lk_last_q  <= m_hit_vec[m_idx] ? ents[m_idx].rng.last  : '0;
      end else begin
        lk_hit_q   <= 1'b0;
        lk_idx_q   <= '0;
        lk_first_q <= '0;
        lk_last_q  <= '0;
      end
    end
  end

  // Entry DEPTH-1 holds zero bounds until it is first written, so this reads 0 before any alloc.
  assign last_ptr       = wr_ptr - 1'b1;
  assign last_first_o   = ents[last_ptr].rng.first;
  assign last_last_o    = ents[last_ptr].rng.last;

  assign lookup_valid_o = lk_valid_q;
  assign lookup_hit_o   = lk_hit_q;
  assign lookup_idx_o   = lk_idx_q;
  assign lookup_first_o = lk_first_q;
  assign lookup_last_o  = lk_last_q;
  assign count_o        = count_q;
  assign full_o         = (count_q == (IDXW+1)'(DEPTH));
  assign overflow_o     = overflow_q;
  assign alloc_err_o    = alloc_err_q;
  assign free_miss_o    = free_miss_q;

endmodule

// File: tb/tb_addr_range_table.sv
// tb/tb_addr_range_table.sv - scoreboard bench for addr_range_table
module tb_addr_range_table;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int IDXW  = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            clear_i = 1'b0, alloc_i = 1'b0, free_i = 1'b0, lookup_i = 1'b0;
  logic [AW-1:0]   alloc_first_i = '0, alloc_last_i = '0, free_first_i = '0, lookup_addr_i = '0;
  logic            lookup_valid_o, lookup_hit_o, full_o, overflow_o, alloc_err_o, free_miss_o;
  logic [IDXW-1:0] lookup_idx_o;
  logic [AW-1:0]   lookup_first_o, lookup_last_o, last_first_o, last_last_o;
  logic [IDXW:0]   count_o;

  addr_range_table #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
    .alloc_i(alloc_i), .alloc_first_i(alloc_first_i), .alloc_last_i(alloc_last_i),
    .free_i(free_i), .free_first_i(free_first_i),
    .lookup_i(lookup_i), .lookup_addr_i(lookup_addr_i),
    .lookup_valid_o(lookup_valid_o), .lookup_hit_o(lookup_hit_o), .lookup_idx_o(lookup_idx_o),
    .lookup_first_o(lookup_first_o), .lookup_last_o(lookup_last_o),
    .last_first_o(last_first_o), .last_last_o(last_last_o),
    .count_o(count_o), .full_o(full_o), .overflow_o(overflow_o),
    .alloc_err_o(alloc_err_o), .free_miss_o(free_miss_o)
  );

  always #5 clk = ~clk;

  typedef struct { bit hit; int idx; logic [AW-1:0] first; logic [AW-1:0] last; } lk_exp_t;
  typedef struct { bit lv; int cnt; bit full; bit ovf; bit aerr; bit fmiss;
                   logic [AW-1:0] lf; logic [AW-1:0] ll; } st_exp_t;

  lk_exp_t lkq[$];
  st_exp_t stq[$];
  int checks = 0;
  int failures = 0;

  // Reference table: plain arrays plus a write index.
  bit            m_valid[DEPTH];
  logic [AW-1:0] m_first[DEPTH];
  logic [AW-1:0] m_last[DEPTH];
  int            m_wr;
  bit            m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0; m_first[i] = '0; m_last[i] = '0;
    end
    m_wr = 0; m_ovf = 1'b0;
  endtask

  task automatic model_step(input bit clr, input bit al, input logic [AW-1:0] af,
                            input logic [AW-1:0] alast, input bit fr, input logic [AW-1:0] ff,
                            input bit lk, input logic [AW-1:0] la);
    lk_exp_t e;
    st_exp_t s;
    bit      match[DEPTH];
    bit      any;
    bit      was_valid;
    int      cnt;
    int      lp;
    if (lk) begin
      e.hit = 1'b0; e.idx = 0; e.first = '0; e.last = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!e.hit && m_valid[i] && m_first[i] <= la && la <= m_last[i]) begin
          e.hit = 1'b1; e.idx = i; e.first = m_first[i]; e.last = m_last[i];
        end
      end
      lkq.push_back(e);
    end
    s.aerr = 1'b0; s.fmiss = 1'b0;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      m_wr = 0; m_ovf = 1'b0;
    end else begin
      any = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        match[i] = m_valid[i] && (m_first[i] == ff);
        any |= match[i];
      end
      was_valid = m_valid[m_wr];
      s.fmiss = fr && !any;
      s.aerr  = al && (af > alast);
      if (fr) for (int i = 0; i < DEPTH; i++) if (match[i]) m_valid[i] = 1'b0;
      if (al && af <= alast) begin
        if (was_valid) m_ovf = 1'b1;
        m_valid[m_wr] = 1'b1; m_first[m_wr] = af; m_last[m_wr] = alast;
        m_wr = (m_wr + 1) % DEPTH;
      end
    end
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) cnt += m_valid[i];
    lp = (m_wr + DEPTH - 1) % DEPTH;
    s.lv = lk; s.cnt = cnt; s.full = (cnt == DEPTH); s.ovf = m_ovf;
    s.lf = m_first[lp]; s.ll = m_last[lp];
    stq.push_back(s);
  endtask

  task automatic drive(input bit clr, input bit al, input logic [AW-1:0] af,
                       input logic [AW-1:0] alast, input bit fr, input logic [AW-1:0] ff,
                       input bit lk, input logic [AW-1:0] la);
    @(negedge clk);
    clear_i = clr; alloc_i = al; alloc_first_i = af; alloc_last_i = alast;
    free_i = fr; free_first_i = ff; lookup_i = lk; lookup_addr_i = la;
    model_step(clr, al, af, alast, fr, ff, lk, la);
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, 0, '0, 0, '0);
  endtask

  // Monitor: per-cycle state expectations, lookup results popped when the DUT presents them.
  always @(posedge clk) begin
    st_exp_t s;
    lk_exp_t e;
    #1;
    if (stq.size() != 0) begin
      s = stq.pop_front();
      chk("lookup_valid", lookup_valid_o, s.lv);
      chk("count", count_o, s.cnt);
      chk("full", full_o, s.full);
      chk("overflow", overflow_o, s.ovf);
      chk("alloc_err", alloc_err_o, s.aerr);
      chk("free_miss", free_miss_o, s.fmiss);
      chk("last_first", last_first_o, s.lf);
      chk("last_last", last_last_o, s.ll);
    end
    if (lookup_valid_o === 1'b1) begin
      if (lkq.size() == 0) begin
        chk("unexpected_lookup", lookup_valid_o, 0);
      end else begin
        e = lkq.pop_front();
        chk("lookup_hit", lookup_hit_o, e.hit);
        chk("lookup_idx", lookup_idx_o, e.idx);
        chk("lookup_first", lookup_first_o, e.first);
        chk("lookup_last", lookup_last_o, e.last);
      end
    end
  end

  initial begin
    logic [AW-1:0] f, l, a;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_count", count_o, 0);
    chk("rst_lookup_valid", lookup_valid_o, 0);
    chk("rst_last_first", last_first_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_full", full_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;

    drive(0, 1, 32'h1000, 32'h10FF, 0, '0, 0, '0);
    drive(0, 1, 32'h2000, 32'h2003, 0, '0, 0, '0);
    @(posedge clk); #2;
    chk("two_alloc_count", count_o, 2);
    chk("two_alloc_last_first", last_first_o, 32'h2000);
    chk("two_alloc_last_last", last_last_o, 32'h2003);
    drive(0, 0, '0, '0, 0, '0, 1, 32'h10FF);
    drive(0, 0, '0, '0, 0, '0, 1, 32'h1100);
    drive(0, 0, '0, '0, 1, 32'h1000, 0, '0);
    drive(0, 0, '0, '0, 0, '0, 1, 32'h1000);
    drive(0, 0, '0, '0, 1, 32'h9999, 0, '0);
    drive(0, 1, 32'h30, 32'h20, 0, '0, 0, '0);
    drive(1, 1, 32'h40, 32'h50, 0, '0, 0, '0);
    @(posedge clk); #2;
    chk("clear_count", count_o, 0);

    for (int k = 0; k <= DEPTH; k++) begin
      f = 32'h1000 + k * 32'h100;
      drive(0, 1, f, f + 32'hF, 0, '0, 0, '0);
    end
    @(posedge clk); #2;
    chk("wrap_overflow", overflow_o, 1);
    chk("wrap_full", full_o, 1);
    chk("wrap_last_first", last_first_o, 32'h1000 + DEPTH * 32'h100);
    drive(0, 1, 32'h8000, 32'h80FF, 1, 32'h1100, 1, 32'h8010);
    drive(0, 0, '0, '0, 0, '0, 1, 32'h8010);

    drive(1, 0, '0, '0, 0, '0, 0, '0);
    drive(0, 1, 32'h900, 32'h9FF, 0, '0, 0, '0);
    drive(0, 1, 32'h500, 32'h5FF, 0, '0, 0, '0);
    drive(0, 1, 32'h700, 32'h7FF, 0, '0, 0, '0);
    drive(0, 1, 32'h400, 32'h600, 0, '0, 0, '0);
    drive(0, 0, '0, '0, 0, '0, 1, 32'h500);
    @(posedge clk); #2;
    chk("overlap_idx", lookup_idx_o, 1);

    for (int n = 0; n < 400; n++) begin
      bit clr, al, fr, lk;
      clr = ($urandom_range(0, 99) < 2);
      al  = !clr && ($urandom_range(0, 99) < 40);
      fr  = !clr && ($urandom_range(0, 99) < 25);
      lk  = ($urandom_range(0, 99) < 60);
      f = AW'($urandom_range(1, 63)) << 4;
      l = ($urandom_range(0, 99) < 15) ? f - AW'($urandom_range(1, 15)) : f + AW'($urandom_range(0, 63));
      a = ($urandom_range(0, 1) == 1) ? m_first[$urandom_range(0, DEPTH - 1)] : AW'($urandom_range(0, 63)) << 4;
      drive(clr, al, f, l, fr, a, lk, AW'($urandom_range(0, 32'h440)));
    end
    idle();
    @(posedge clk); #3;
    chk("stq_drained", stq.size(), 0);
    chk("lkq_drained", lkq.size(), 0);

    drive(0, 1, 32'hA00, 32'hAFF, 0, '0, 0, '0);
    drive(0, 0, '0, '0, 0, '0, 1, 32'hA10);
    @(posedge clk); #2;
    rst_ni = 1'b0; lookup_i = 1'b0; alloc_i = 1'b0;
    #1;
    chk("arst_lookup_valid", lookup_valid_o, 0);
    chk("arst_lookup_hit", lookup_hit_o, 0);
    chk("arst_lookup_first", lookup_first_o, 0);
    chk("arst_count", count_o, 0);
    chk("arst_last_first", last_first_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
    idle();
    @(posedge clk); #3;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
